// File: rtl/sram_access_target.sv
// SRAM-side responder for the sram_access request/response interface.
// Byte-enabled writes and 64-bit reads on a word array, with configurable ack wait-states and response latency.
module sram_access_target #(
    parameter int ADDR_BITS    = 10,
    parameter int RESP_LATENCY = 1,
    parameter int ACK_WAIT     = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sram_access_req__valid,
    input  logic [7:0]  sram_access_req__id,
    input  logic        sram_access_req__read_not_write,
    input  logic [7:0]  sram_access_req__byte_enable,
    input  logic [31:0] sram_access_req__address,
    input  logic [63:0] sram_access_req__write_data,
    output logic        sram_access_resp__ack,
    output logic        sram_access_resp__valid,
    output logic [7:0]  sram_access_resp__id,
    output logic [63:0] sram_access_resp__data
);

    localparam int         DEPTH      = 1 << ADDR_BITS;
    localparam logic [3:0] ACK_WAIT_C = 4'(ACK_WAIT);

    logic [3:0]                         wait_cnt_r;
    logic [3:0]                         wait_cnt_nxt_s;
    logic                               ack_s;
    logic                               wr_en_s;
    logic [ADDR_BITS-1:0]               index_s;
    logic [63:0]                        rd_word_s;
    logic [63:0]                        mem_r [DEPTH];
    logic [RESP_LATENCY-1:0]            pipe_valid_r;
    logic [RESP_LATENCY-1:0][7:0]       pipe_id_r;
    logic [RESP_LATENCY-1:0][63:0]      pipe_data_r;
    logic                               unused_addr_s;

    // Upper address bits alias onto the array and are deliberately dropped.
    assign index_s       = sram_access_req__address[ADDR_BITS-1:0];
    assign unused_addr_s = ^{1'b0, sram_access_req__address[31:ADDR_BITS]};
    assign rd_word_s     = mem_r[index_s];

    // Ack decision; held low during reset so no request slips in while the pipeline is cleared.
    always_comb begin
        ack_s = 1'b0;
        if (reset_n && sram_access_req__valid && (wait_cnt_r == ACK_WAIT_C)) begin
            ack_s = 1'b1;
        end else begin
            ack_s = 1'b0;
        end
    end

    // Next wait count: restart on idle or after an accept, otherwise count up to the wait limit.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (!sram_access_req__valid || ack_s) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (wait_cnt_r < ACK_WAIT_C) begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Wait-state counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    assign wr_en_s = ack_s && !sram_access_req__read_not_write;

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_access_req__byte_enable[b]) begin
                    mem_r[index_s][8*b +: 8] <= sram_access_req__write_data[8*b +: 8];
                end
            end
        end
    end

    // Response shift register: stage 0 loads at the ack edge, the last stage drives the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_r <= '0;
            pipe_id_r    <= '0;
            pipe_data_r  <= '0;
        end else begin
            pipe_valid_r[0] <= ack_s;
            pipe_id_r[0]    <= ack_s ? sram_access_req__id : 8'd0;
            pipe_data_r[0]  <= (ack_s && sram_access_req__read_not_write) ? rd_word_s : 64'd0;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_id_r[i]    <= pipe_id_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
            end
        end
    end

    assign sram_access_resp__ack   = ack_s;
    assign sram_access_resp__valid = pipe_valid_r[RESP_LATENCY-1];
    assign sram_access_resp__id    = pipe_id_r[RESP_LATENCY-1];
    assign sram_access_resp__data  = pipe_data_r[RESP_LATENCY-1];

endmodule

// File: tb/tb_sram_access_target.sv
// Directed bench for sram_access_target: four instances with different latency/wait settings share one request bus.
module tb_sram_access_target;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic [7:0]  id;
    logic        rnw;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wdata;

    logic        ack0, ack1, ack2, ack3;
    logic        rv0, rv1, rv2, rv3;
    logic [7:0]  rid0, rid1, rid2, rid3;
    logic [63:0] rd0, rd1, rd2, rd3;

    int passed = 0;
    int total  = 0;

    logic [31:0] c_addr [3];
    logic [63:0] c_data [3];

    sram_access_target #(.ADDR_BITS(10), .RESP_LATENCY(1), .ACK_WAIT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .sram_access_req__valid(valid), .sram_access_req__id(id),
        .sram_access_req__read_not_write(rnw), .sram_access_req__byte_enable(be),
        .sram_access_req__address(addr), .sram_access_req__write_data(wdata),
        .sram_access_resp__ack(ack0), .sram_access_resp__valid(rv0),
        .sram_access_resp__id(rid0), .sram_access_resp__data(rd0));

    sram_access_target #(.ADDR_BITS(10), .RESP_LATENCY(4), .ACK_WAIT(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .sram_access_req__valid(valid), .sram_access_req__id(id),
        .sram_access_req__read_not_write(rnw), .sram_access_req__byte_enable(be),
        .sram_access_req__address(addr), .sram_access_req__write_data(wdata),
        .sram_access_resp__ack(ack1), .sram_access_resp__valid(rv1),
        .sram_access_resp__id(rid1), .sram_access_resp__data(rd1));

    sram_access_target #(.ADDR_BITS(10), .RESP_LATENCY(2), .ACK_WAIT(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .sram_access_req__valid(valid), .sram_access_req__id(id),
        .sram_access_req__read_not_write(rnw), .sram_access_req__byte_enable(be),
        .sram_access_req__address(addr), .sram_access_req__write_data(wdata),
        .sram_access_resp__ack(ack2), .sram_access_resp__valid(rv2),
        .sram_access_resp__id(rid2), .sram_access_resp__data(rd2));

    sram_access_target #(.ADDR_BITS(10), .RESP_LATENCY(3), .ACK_WAIT(0)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .sram_access_req__valid(valid), .sram_access_req__id(id),
        .sram_access_req__read_not_write(rnw), .sram_access_req__byte_enable(be),
        .sram_access_req__address(addr), .sram_access_req__write_data(wdata),
        .sram_access_resp__ack(ack3), .sram_access_resp__valid(rv3),
        .sram_access_resp__id(rid3), .sram_access_resp__data(rd3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [7:0] i, input logic r,
                       input logic [7:0] b, input logic [31:0] a, input logic [63:0] d);
        valid = v; id = i; rnw = r; be = b; addr = a; wdata = d;
    endtask

    task automatic idle();
        req(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 64'h0);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        c_addr[0] = 32'h5;  c_data[0] = 64'h1122334455667788;
        c_addr[1] = 32'h10; c_data[1] = 64'hFFFFFFFFAABBCCDD;
        c_addr[2] = 32'h0;  c_data[2] = 64'h1;

        // Reset state, including ack suppressed while reset is low.
        reset_n = 1'b0;
        idle();
        repeat (2) cyc();
        req(1'b1, 8'h99, 1'b1, 8'h00, 32'h5, 64'h0);
        #1;
        chk("rst_ack", ack0, 1'b0);
        chk("rst_valid", rv0, 1'b0);
        chk("rst_id", rid0, 8'h00);
        chk("rst_data", rd0, 64'h0);
        idle();
        cyc();
        reset_n = 1'b1;

        // Full write then read back with latency 1.
        cyc(); req(1'b1, 8'h3C, 1'b0, 8'hFF, 32'h5, 64'h1122334455667788); #1;
        chk("a_wr_ack", ack0, 1'b1);
        chk("a_pre_valid", rv0, 1'b0);
        cyc(); req(1'b1, 8'h3D, 1'b1, 8'h00, 32'h5, 64'h0); #1;
        chk("a_rd_ack", ack0, 1'b1);
        chk("a_wr_resp_valid", rv0, 1'b1);
        chk("a_wr_resp_id", rid0, 8'h3C);
        chk("a_wr_resp_data", rd0, 64'h0);
        cyc(); idle(); #1;
        chk("a_rd_resp_valid", rv0, 1'b1);
        chk("a_rd_resp_id", rid0, 8'h3D);
        chk("a_rd_resp_data", rd0, 64'h1122334455667788);
        cyc(); #1;
        chk("a_idle_valid", rv0, 1'b0);
        chk("a_idle_id", rid0, 8'h00);
        chk("a_idle_data", rd0, 64'h0);

        // Partial write, then an empty byte-enable write that must not disturb the word.
        cyc(); req(1'b1, 8'h01, 1'b0, 8'hFF, 32'h10, 64'hFFFFFFFFFFFFFFFF);
        cyc(); req(1'b1, 8'h02, 1'b0, 8'h0F, 32'h10, 64'h00000000AABBCCDD);
        cyc(); req(1'b1, 8'h03, 1'b1, 8'h00, 32'h10, 64'h0);
        cyc(); req(1'b1, 8'h04, 1'b0, 8'h00, 32'h10, 64'h0); #1;
        chk("p_rd_id", rid0, 8'h03);
        chk("p_rd_data", rd0, 64'hFFFFFFFFAABBCCDD);
        cyc(); req(1'b1, 8'h05, 1'b1, 8'h00, 32'h10, 64'h0); #1;
        chk("p_be0_valid", rv0, 1'b1);
        chk("p_be0_id", rid0, 8'h04);
        cyc(); idle(); #1;
        chk("p_be0_rd_data", rd0, 64'hFFFFFFFFAABBCCDD);

        // Upper address bits alias onto index 0.
        cyc(); req(1'b1, 8'h06, 1'b0, 8'hFF, 32'h00000400, 64'h1);
        cyc(); req(1'b1, 8'h07, 1'b1, 8'h00, 32'h0, 64'h0);
        cyc(); idle(); #1;
        chk("alias_id", rid0, 8'h07);
        chk("alias_data", rd0, 64'h1);

        // Wait-state instance: preload a word, letting the 4-cycle pipeline drain.
        cyc(); idle();
        for (int c = 0; c < 4; c++) begin
            cyc(); req(1'b1, 8'h40, 1'b0, 8'hFF, 32'h7, 64'h0123456789ABCDEF); #1;
            chk("b_pre_ack", ack1, c == 3);
        end
        cyc(); idle();
        repeat (5) cyc();

        // Read held valid from cycle 0: ack in cycle 3, response in cycle 7.
        for (int c = 0; c < 9; c++) begin
            cyc();
            if (c < 4) req(1'b1, 8'h41, 1'b1, 8'h00, 32'h7, 64'h0);
            else idle();
            #1;
            chk("b_ack", ack1, c == 3);
            chk("b_resp_valid", rv1, c == 7);
            if (c == 7) begin
                chk("b_resp_id", rid1, 8'h41);
                chk("b_resp_data", rd1, 64'h0123456789ABCDEF);
            end
        end

        // Valid dropped in cycle 2 restarts the count: ack in cycle 6, response in cycle 10.
        for (int c = 0; c < 11; c++) begin
            cyc();
            if (c != 2 && c <= 6) req(1'b1, 8'h42, 1'b1, 8'h00, 32'h7, 64'h0);
            else idle();
            #1;
            chk("b2_ack", ack1, c == 6);
            chk("b2_resp_valid", rv1, c == 10);
            if (c == 10) begin
                chk("b2_resp_id", rid1, 8'h42);
                chk("b2_resp_data", rd1, 64'h0123456789ABCDEF);
            end
        end

        // Back-to-back reads with latency 2, overlapping ack and response.
        cyc(); idle();
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (c < 3) req(1'b1, 8'(c + 1), 1'b1, 8'h00, c_addr[c], 64'h0);
            else idle();
            #1;
            chk("c_ack", ack2, c < 3);
            chk("c_resp_valid", rv2, (c >= 2) && (c <= 4));
            if (c >= 2 && c <= 4) begin
                chk("c_resp_id", rid2, 8'(c - 1));
                chk("c_resp_data", rd2, c_data[c-2]);
            end
        end

        // Reset one cycle after a read ack drops the pending response.
        cyc(); req(1'b1, 8'h77, 1'b1, 8'h00, 32'h5, 64'h0); #1;
        chk("d_ack", ack3, 1'b1);
        cyc(); idle(); reset_n = 1'b0; #1;
        chk("d_rst_valid1", rv3, 1'b0);
        cyc(); req(1'b1, 8'h88, 1'b1, 8'h00, 32'h5, 64'h0); #1;
        chk("d_rst_ack", ack3, 1'b0);
        chk("d_rst_valid2", rv3, 1'b0);
        cyc(); idle(); #1;
        chk("d_rst_valid3", rv3, 1'b0);
        cyc(); reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("d_post_valid", rv3, 1'b0);
            cyc();
        end

        // Array contents survive reset.
        req(1'b1, 8'h78, 1'b1, 8'h00, 32'h5, 64'h0); #1;
        chk("d_rd_ack", ack3, 1'b1);
        cyc(); idle();
        cyc(); #1;
        chk("d_rd_early", rv3, 1'b0);
        cyc(); #1;
        chk("d_rd_valid", rv3, 1'b1);
        chk("d_rd_id", rid3, 8'h78);
        chk("d_rd_data", rd3, 64'h1122334455667788);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
